// File: rtl/dlx_ifetch_stage_if.sv
// Bundle between the DLX fetch stage, instruction memory and the decode stage.
// The master side is the fetch stage; the slave side is the memory/decode environment.
interface dlx_ifetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic [5:0]  id_opcode;
    logic [5:0]  id_function;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc4, id_opcode, id_function,
        input  imem_ready, imem_rdata, id_stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc4, id_opcode, id_function,
        output imem_ready, imem_rdata, id_stall, redirect, redirect_pc
    );
endinterface

// File: rtl/dlx_ifetch_stage.sv
// DLX instruction-fetch stage with IF/ID pipeline register: single outstanding
// imem request, one-entry skid buffer for ID stalls, and redirect handling.
module dlx_ifetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    dlx_ifetch_stage_if.master bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2,
        HOLD    = 2'd3
    } state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    state_t      state_r;
    logic [31:0] pc_r;
    logic        req_r;
    logic        pend_r;
    logic [31:0] pend_pc_r;
    logic        skid_valid_r;
    logic [31:0] skid_instr_r;
    logic [31:0] skid_pc4_r;
    logic        id_valid_r;
    logic [31:0] id_instr_r;
    logic [31:0] id_pc4_r;

    logic [31:0] redir_tgt_s;
    logic [31:0] pc_inc_s;

    assign redir_tgt_s = word_align(bus.redirect_pc);
    assign pc_inc_s    = pc_r + 32'd4;

    // Fetch FSM, PC, pending redirect, skid buffer and IF/ID register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            pc_r         <= RESET_PC;
            req_r        <= 1'b0;
            pend_r       <= 1'b0;
            pend_pc_r    <= 32'h0000_0000;
            skid_valid_r <= 1'b0;
            skid_instr_r <= NOP_INSTR;
            skid_pc4_r   <= 32'h0000_0000;
            id_valid_r   <= 1'b0;
            id_instr_r   <= NOP_INSTR;
            id_pc4_r     <= 32'h0000_0000;
        end else begin
            // Redirect squashes IF/ID; otherwise a non-stalled ID sees a bubble
            // unless a state below loads a fresh instruction. id_pc4 holds.
            if (bus.redirect || !bus.id_stall) begin
                id_valid_r <= 1'b0;
                id_instr_r <= NOP_INSTR;
            end

            case (state_r)
                IDLE: begin
                    if (bus.redirect) begin
                        pc_r <= redir_tgt_s;
                    end
                    state_r <= FETCH;
                    req_r   <= 1'b1;
                end

                FETCH: begin
                    if (bus.imem_ready) begin
                        if (bus.redirect) begin
                            pc_r <= redir_tgt_s;
                        end else if (!bus.id_stall) begin
                            id_valid_r <= 1'b1;
                            id_instr_r <= bus.imem_rdata;
                            id_pc4_r   <= pc_inc_s;
                            pc_r       <= pc_inc_s;
                        end else begin
                            skid_valid_r <= 1'b1;
                            skid_instr_r <= bus.imem_rdata;
                            skid_pc4_r   <= pc_inc_s;
                            pc_r         <= pc_inc_s;
                            state_r      <= HOLD;
                            req_r        <= 1'b0;
                        end
                    end else if (bus.redirect) begin
                        // Request still outstanding at the old address: remember
                        // the target and throw the response away when it lands.
                        pend_r    <= 1'b1;
                        pend_pc_r <= redir_tgt_s;
                        state_r   <= DISCARD;
                    end
                end

                DISCARD: begin
                    if (bus.imem_ready) begin
                        if (bus.redirect) begin
                            pc_r <= redir_tgt_s;
                        end else if (pend_r) begin
                            pc_r <= pend_pc_r;
                        end
                        pend_r  <= 1'b0;
                        state_r <= FETCH;
                    end else if (bus.redirect) begin
                        pend_pc_r <= redir_tgt_s;
                    end
                end

                HOLD: begin
                    if (bus.redirect) begin
                        skid_valid_r <= 1'b0;
                        pc_r         <= redir_tgt_s;
                        state_r      <= FETCH;
                        req_r        <= 1'b1;
                    end else if (!bus.id_stall) begin
                        id_valid_r   <= skid_valid_r;
                        id_instr_r   <= skid_instr_r;
                        id_pc4_r     <= skid_pc4_r;
                        skid_valid_r <= 1'b0;
                        state_r      <= FETCH;
                        req_r        <= 1'b1;
                    end
                end

                default: begin
                    state_r <= IDLE;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req    = req_r;
    assign bus.imem_addr   = pc_r;
    assign bus.id_valid    = id_valid_r;
    assign bus.id_instr    = id_instr_r;
    assign bus.id_pc4      = id_pc4_r;
    assign bus.id_opcode   = id_instr_r[31:26];
    assign bus.id_function = id_instr_r[5:0];

endmodule

// File: doc/dlx_ifetch_stage.md
Name: dlx_ifetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the pipelined DLX core.
- Holds the PC and issues single-outstanding requests to instruction memory.
- Absorbs memory wait states, ID stalls and taken-branch/jump redirects.
- Presents the registered instruction, its PC+4 and pre-split OpCode/Function fields to the decode stage, whose control decoder consumes them.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction placed in IF/ID when it holds a bubble.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request; held until imem_ready.
- imem_addr  out  32  fetch address (word aligned, low 2 bits always 0).
- imem_ready  in  1  imem_rdata valid this cycle; completes the request.
- imem_rdata  in  32  fetched instruction.
- id_stall  in  1  decode stage cannot accept; IF/ID holds.
- redirect  in  1  taken branch/jump/trap-return from downstream; one-cycle pulse.
- redirect_pc  in  32  new fetch target; low 2 bits ignored.
- id_valid  out  1  IF/ID holds a real instruction.
- id_instr  out  32  IF/ID instruction.
- id_pc4  out  32  address of id_instr plus 4 (JAL link value).
- id_opcode  out  6  id_instr bits 31..26.
- id_function  out  6  id_instr bits 5..0.

Behaviour:
- Reset (async, rst_n=0): state IDLE; pc=RESET_PC; imem_req=0; imem_addr=RESET_PC; id_valid=0; id_instr=NOP_INSTR; id_pc4=0; pending-redirect flag clear; skid buffer empty.
- imem_req and imem_addr are driven from registered state only; imem_addr=pc at all times.
- FSM states and transitions:
  - IDLE: imem_req=0. Unconditionally moves to FETCH the next cycle. A redirect here loads pc and still moves to FETCH.
  - FETCH: imem_req=1.
    - Without imem_ready, a redirect sets the pending flag, captures redirect_pc into pend_pc and moves to DISCARD. pc/imem_addr do not change while the request is outstanding.
    - With imem_ready and redirect in the same cycle, the data is discarded, pc=redirect_pc and the state stays FETCH.
    - With imem_ready, no redirect and id_stall=0: load IF/ID (id_valid=1, id_instr=imem_rdata, id_pc4=pc+4); pc=pc+4; stay FETCH.
    - With imem_ready, no redirect and id_stall=1: capture the instruction and pc+4 in the skid buffer; pc=pc+4; move to HOLD.
  - DISCARD: imem_req=1 at the old address.
    - A further redirect overwrites pend_pc (latest wins).
    - On imem_ready the data is dropped, pc=pend_pc (or redirect_pc if redirect is asserted that cycle), and the state moves to FETCH.
  - HOLD: imem_req=0.
    - When id_stall=0, the skid contents move to IF/ID and the state moves to FETCH.
    - A redirect empties the skid buffer, sets pc=redirect_pc and moves to FETCH.
- IF/ID register:
  - id_stall=1 with no redirect: all id_* outputs hold.
  - redirect=1: id_valid=0 and id_instr=NOP_INSTR next cycle, regardless of id_stall. Redirect has priority over stall; no delay slot.
  - id_stall=0 with no new instruction: id_valid=0 and id_instr=NOP_INSTR (bubble); id_pc4 holds.
- Timing:
  - Zero-wait memory: the instruction at address A requested in cycle n appears on id_* in cycle n+1.
  - Throughput is one instruction per cycle. Redirect penalty is one bubble.
- Arithmetic:
  - pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - redirect_pc[1:0] is forced to 0 before loading.
- Mid-operation reset: an async assert immediately returns all state to reset values. An outstanding request is abandoned; imem must tolerate the dropped imem_req.
- id_opcode and id_function are pure combinational slices of id_instr.

Test Plan:
- Reset with RESET_PC=0x100, zero-wait memory returning addr-tagged words: cycle 1 requests 0x100. id_pc4 then shows 0x104, 0x108, 0x10C on consecutive cycles with id_valid=1 continuously.
- imem_ready delayed 3 cycles at 0x200: imem_addr holds 0x200 for 4 cycles. id_valid=0 throughout the wait; then id_instr=word(0x200) and id_pc4=0x204.
- id_stall=1 for 2 cycles while word(0x10) returns: the word is held in HOLD with imem_req=0. After the stall drops, id_instr=word(0x10) and the next request is 0x14, with nothing lost or duplicated.
- redirect to 0x400 while a request to 0x20 is waiting: the state enters DISCARD, and the 0x20 data is dropped when ready arrives. The next request is 0x400, and id_valid=0 until word(0x400) arrives.
- redirect with redirect_pc=0x503 coincident with id_stall=1 and imem_ready: IF/ID becomes a bubble (id_instr=NOP_INSTR) and the next request is 0x500.
- pc=0xFFFF_FFFC: id_pc4=0 and the next request is 0. Asserting rst_n=0 mid-wait drops imem_req the same cycle and pc returns to RESET_PC.
